md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit beside the E-stage ALU of the 5-stage pipeline. It owns the HI/LO registers.
//  Consumes operands forwarded into E (v1E/v2E) and reports busy, which the D-stage hazard unit uses to stall.
//  MFHI/MFLO in E read hi/lo directly; results feed the E->M vNew path like ALU results.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD family); legal range >=1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; legal range >=1
// PORTS
//  clk    in   1   rising-edge clock
//  reset  in   1   asynchronous, active-low; clears all state immediately
//  start  in   1   1 = issue op this cycle (the E-stage instr is an md op, not a bubble)
//  op     in   4   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
//  a      in   32  rs value (forwarded)
//  b      in   32  rt value (forwarded)
//  busy   out  1   1 = multi-cycle op in progress
//  done   out  1   one-cycle pulse: HI/LO just committed by a multi-cycle op
//  hi     out  32  HI register
//  lo     out  32  LO register
// BEHAVIOUR
//  - Reset (reset==0, async): busy=0, done=0, hi=0, lo=0, counter=0, pending result=0, state=IDLE.
//  - States: IDLE, RUN. Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - IDLE + start + mult/div op at edge t:
//    - Compute the full 64-bit result in that cycle and register it into pending{hi,lo}.
//    - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from cycle t+1.
//  - RUN: the counter decrements each edge. At the edge where the counter goes 1->0:
//    - hi/lo <= pending; state becomes IDLE.
//    - In the following cycle busy=0 and done=1 for exactly one cycle.
//    - Net effect: busy is high for exactly N cycles.
//  - MTHI/MTLO (IDLE + start): hi<=a or lo<=a at the next edge. No busy, no done.
//  - op 0, undefined op, or start=0: no state change.
//  - start while busy: ignored entirely. The core guarantees this never happens.
//    - D stalls while the D instr is an md op (incl. MFHI/MFLO/MTHI/MTLO) and (busy | start).
//  - hi/lo hold their old values throughout RUN; pending results are never visible early.
//  - MULT: signed 32x32->64. MULTU: unsigned. Result: {hi,lo} = product.
//  - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
//  - DIVU: unsigned quotient/remainder.
//  - Divide by zero (b==0, DIV or DIVU): full DIV_CYCLES busy, done pulses, hi/lo unchanged.
//  - Asserting reset mid-RUN aborts the op: pending is discarded and busy falls immediately.
//  - done and busy are never both 1.
// CONFIGURATION
//  MD_MADD_EN defined:
//   - ops 7..10 are legal, with MULT_CYCLES latency.
//   - At start, pending = {hi,lo} +/- (a*b), using the hi/lo current at the start edge.
//   - Signed for MADD/MSUB, unsigned for MADDU/MSUBU; 64-bit wrap-around.
//  MD_MADD_EN undefined:
//   - ops 7..10 are decoded as NOP: no busy, no state change. The adder/subtractor is not synthesised.
// TESTING
//  1. MULT a=0xFFFFFFFE b=3 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA, done 1 cycle.
//     MULTU with the same operands -> hi=0x00000002 lo=0xFFFFFFFA.
//  2. DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU a=7 b=2 -> lo=3 hi=1.
//  3. Preload hi=0x11 lo=0x22 via MTHI/MTLO; DIV a=5 b=0 -> busy 10, done pulses, hi=0x11 lo=0x22.
//  4. MTHI a=0x1234 while idle -> hi=0x1234 next cycle, busy stays 0.
//     start+MULT during busy -> ignored, first result unchanged.
//  5. DIV issued; reset low during busy cycle 3 -> busy=0 hi=0 lo=0 immediately.
//     After reset is released: no done, state IDLE.
//  6. MD_MADD_EN on: hi=0 lo=5, MADD a=2 b=3 -> after 5 cycles lo=11 hi=0.
//     MSUBU a=1 b=12 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF.
//     MD_MADD_EN off: op 7 -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; results commit after a fixed latency.
// Optional MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (7..10).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     pend_hi;
  logic [31:0]     pend_lo;

  // Full-width products; the low 64 bits of an extended product are the exact 32x32 result.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide through magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic [31:0] mag_a, mag_b, mag_q, mag_r, quo_s, rem_s, quo_u, rem_u;
  logic        b_zero;
  assign b_zero = (b == 32'd0);
  assign mag_a  = a[31] ? (~a + 32'd1) : a;
  assign mag_b  = b[31] ? (~b + 32'd1) : b;
  assign mag_q  = b_zero ? 32'd0 : (mag_a / mag_b);
  assign mag_r  = b_zero ? 32'd0 : (mag_a % mag_b);
  assign quo_s  = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign rem_s  = a[31] ? (~mag_r + 32'd1) : mag_r;
  assign quo_u  = b_zero ? 32'd0 : (a / b);
  assign rem_u  = b_zero ? 32'd0 : (a % b);

  logic            md_op;
  logic [CntW-1:0] cycles;
  logic [63:0]     result;

  always_comb begin
    md_op  = 1'b0;
    cycles = '0;
    // Divide by zero falls through with the current HI/LO so the commit is a no-op.
    result = {hi, lo};
    case (op)
      OpMult:  begin md_op = 1'b1; cycles = MultCnt; result = prod_s; end
      OpMultu: begin md_op = 1'b1; cycles = MultCnt; result = prod_u; end
      OpDiv: begin
        md_op  = 1'b1;
        cycles = DivCnt;
        if (!b_zero) result = {rem_s, quo_s};
      end
      OpDivu: begin
        md_op  = 1'b1;
        cycles = DivCnt;
        if (!b_zero) result = {rem_u, quo_u};
      end
`ifdef MD_MADD_EN
      OpMadd:  begin md_op = 1'b1; cycles = MultCnt; result = {hi, lo} + prod_s; end
      OpMaddu: begin md_op = 1'b1; cycles = MultCnt; result = {hi, lo} + prod_u; end
      OpMsub:  begin md_op = 1'b1; cycles = MultCnt; result = {hi, lo} - prod_s; end
      OpMsubu: begin md_op = 1'b1; cycles = MultCnt; result = {hi, lo} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (md_op) begin
              {pend_hi, pend_lo} <= result;
              cnt                <= cycles;
              state              <= StRun;
              busy               <= 1'b1;
            end else if (op == OpMthi) begin
              hi <= a;
            end else if (op == OpMtlo) begin
              lo <= a;
            end
          end
        end
        StRun: begin
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
